sargantana_icache_ctrl: RTL and testbench

SARGANTANA_ICACHE_CTRL -- requirements
Module: sargantana_icache_ctrl

---
 rtl/sargantana_icache_pkg.sv | 20 ++
 rtl/sargantana_icache_replace.sv | 34 +++
 rtl/sargantana_icache_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_sargantana_icache_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sargantana_icache_pkg.sv
// Shared types for the instruction-cache controller: FSM state encoding.
// Imported by the controller top and its replacement-counter sub-module.
package sargantana_icache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        TLB_WAIT,
        FILL_REQ,
        FILL_WAIT,
        KILL_DRAIN,
        FLUSH
    } icache_ctrl_state_t;

    // States in which a fetch request is considered live towards the core.
    function automatic logic is_req_live(input icache_ctrl_state_t st);
        return (st == COMPARE) || (st == TLB_WAIT) || (st == FILL_REQ) || (st == FILL_WAIT);
    endfunction

endpackage

// File: rtl/sargantana_icache_replace.sv
// Round-robin victim-way counter; advances by one way per completed cached fill.
// Wraps naturally because the way count is a power of two.
module sargantana_icache_replace
    import sargantana_icache_pkg::*;
#(
    parameter int unsigned N_WAY = 4
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     inc_i,
    output logic [$clog2(N_WAY)-1:0] way_o
);

    logic [$clog2(N_WAY)-1:0] way_q;
    logic [$clog2(N_WAY)-1:0] way_d;

    always_comb begin
        way_d = way_q;
        if (inc_i) begin
            way_d = way_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            way_q <= '0;
        end else begin
            way_q <= way_d;
        end
    end

    assign way_o = way_q;

endmodule

// File: rtl/sargantana_icache_ctrl.sv
// Instruction-cache control FSM: lookup, TLB wait, line fill, kill drain and set-invalidate sweep.
// Hit responds one cycle after acceptance; flush requests arriving mid-operation are deferred to IDLE.
module sargantana_icache_ctrl
    import sargantana_icache_pkg::*;
#(
    parameter int unsigned ICACHE_N_WAY = 4,
    parameter int unsigned ICACHE_DEPTH = 64
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic                            ireq_valid_i,
    output logic                            ireq_ready_o,
    input  logic                            ireq_kill_i,
    input  logic                            flush_i,
    input  logic                            cache_enable_i,
    input  logic                            tresp_valid_i,
    input  logic                            tresp_miss_i,
    input  logic                            tresp_xcpt_i,
    input  logic                            cmp_hit_i,
    output logic                            ifill_req_valid_o,
    input  logic                            ifill_req_ready_i,
    input  logic                            ifill_resp_valid_i,
    output logic                            resp_valid_o,
    output logic                            resp_xcpt_o,
    output logic                            cmp_enable_o,
    output logic                            valid_ireq_o,
    output logic                            ifill_process_started_o,
    output logic [$clog2(ICACHE_N_WAY)-1:0] way_to_replace_o,
    output logic                            flush_en_o,
    output logic [$clog2(ICACHE_DEPTH)-1:0] flush_idx_o,
    output logic                            flush_done_o
);

    localparam int unsigned IDX_W = $clog2(ICACHE_DEPTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ICACHE_DEPTH - 1);

    icache_ctrl_state_t state_q, state_d;
    logic               flush_pend_q, flush_pend_d;
    logic [IDX_W-1:0]   flush_idx_q, flush_idx_d;
    logic               fill_done;
    logic               tlb_ok;

    assign tlb_ok = tresp_valid_i && !tresp_miss_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            flush_pend_q <= 1'b0;
            flush_idx_q  <= '0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            flush_idx_q  <= flush_idx_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        flush_idx_d  = flush_idx_q;
        fill_done    = 1'b0;

        // Flushes seen while busy are remembered and replayed from IDLE.
        if (flush_i && (state_q != IDLE) && (state_q != FLUSH)) begin
            flush_pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (flush_i || flush_pend_q) begin
                    state_d      = FLUSH;
                    flush_pend_d = 1'b0;
                    flush_idx_d  = '0;
                end else if (ireq_valid_i) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (ireq_kill_i) begin
                    state_d = IDLE;
                end else if (!tlb_ok) begin
                    state_d = TLB_WAIT;
                end else if (tresp_xcpt_i || (cmp_hit_i && cache_enable_i)) begin
                    state_d = IDLE;
                end else begin
                    state_d = FILL_REQ;
                end
            end
            TLB_WAIT: begin
                if (ireq_kill_i) begin
                    state_d = IDLE;
                end else if (tlb_ok) begin
                    state_d = COMPARE;
                end
            end
            FILL_REQ: begin
                if (ireq_kill_i) begin
                    state_d = IDLE;
                end else if (ifill_req_ready_i) begin
                    state_d = FILL_WAIT;
                end
            end
            FILL_WAIT: begin
                if (ifill_resp_valid_i) begin
                    state_d   = IDLE;
                    fill_done = !ireq_kill_i;
                end else if (ireq_kill_i) begin
                    state_d = KILL_DRAIN;
                end
            end
            KILL_DRAIN: begin
                if (ifill_resp_valid_i) begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (flush_idx_q == IDX_LAST) begin
                    state_d     = IDLE;
                    flush_idx_d = '0;
                end else begin
                    flush_idx_d = flush_idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ireq_ready_o            = 1'b0;
        ifill_req_valid_o       = 1'b0;
        resp_valid_o            = 1'b0;
        resp_xcpt_o             = 1'b0;
        cmp_enable_o            = 1'b0;
        ifill_process_started_o = 1'b0;
        flush_en_o              = 1'b0;
        flush_done_o            = 1'b0;
        valid_ireq_o            = is_req_live(state_q);

        case (state_q)
            IDLE: begin
                ireq_ready_o = !flush_i && !flush_pend_q;
            end
            COMPARE: begin
                cmp_enable_o = 1'b1;
                if (!ireq_kill_i && tlb_ok) begin
                    if (tresp_xcpt_i) begin
                        resp_valid_o = 1'b1;
                        resp_xcpt_o  = 1'b1;
                    end else if (cmp_hit_i && cache_enable_i) begin
                        resp_valid_o = 1'b1;
                    end
                end
            end
            FILL_REQ: begin
                // Withdrawn in the kill cycle so an aborted request never handshakes.
                ifill_req_valid_o = !ireq_kill_i;
            end
            FILL_WAIT: begin
                ifill_process_started_o = 1'b1;
                resp_valid_o            = ifill_resp_valid_i && !ireq_kill_i;
            end
            KILL_DRAIN: begin
                ifill_process_started_o = 1'b1;
            end
            FLUSH: begin
                flush_en_o   = 1'b1;
                flush_done_o = (flush_idx_q == IDX_LAST);
            end
            default: begin
                ireq_ready_o = 1'b0;
            end
        endcase
    end

    assign flush_idx_o = flush_idx_q;

    sargantana_icache_replace #(
        .N_WAY (ICACHE_N_WAY)
    ) u_replace (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .inc_i  (fill_done && cache_enable_i),
        .way_o  (way_to_replace_o)
    );

endmodule

// File: tb/tb_sargantana_icache_ctrl.sv
// Bench for sargantana_icache_ctrl: COMPARE decision table, randomized transactions against
// a timing/outcome model, and directed kill, flush and reset sequences.
module tb_sargantana_icache_ctrl;

    logic       clk_i = 1'b0;
    logic       rstn_i;
    logic       ireq_valid_i, ireq_kill_i, flush_i, cache_enable_i;
    logic       tresp_valid_i, tresp_miss_i, tresp_xcpt_i, cmp_hit_i;
    logic       ifill_req_ready_i, ifill_resp_valid_i;
    logic       ireq_ready_o, ifill_req_valid_o, resp_valid_o, resp_xcpt_o;
    logic       cmp_enable_o, valid_ireq_o, ifill_process_started_o;
    logic [1:0] way_to_replace_o;
    logic       flush_en_o, flush_done_o;
    logic [5:0] flush_idx_o;

    int n_tests = 0;
    int n_fail  = 0;
    int way_exp = 0;

    always #5 clk_i = ~clk_i;

    sargantana_icache_ctrl dut (
        .clk_i                   (clk_i),
        .rstn_i                  (rstn_i),
        .ireq_valid_i            (ireq_valid_i),
        .ireq_ready_o            (ireq_ready_o),
        .ireq_kill_i             (ireq_kill_i),
        .flush_i                 (flush_i),
        .cache_enable_i          (cache_enable_i),
        .tresp_valid_i           (tresp_valid_i),
        .tresp_miss_i            (tresp_miss_i),
        .tresp_xcpt_i            (tresp_xcpt_i),
        .cmp_hit_i               (cmp_hit_i),
        .ifill_req_valid_o       (ifill_req_valid_o),
        .ifill_req_ready_i       (ifill_req_ready_i),
        .ifill_resp_valid_i      (ifill_resp_valid_i),
        .resp_valid_o            (resp_valid_o),
        .resp_xcpt_o             (resp_xcpt_o),
        .cmp_enable_o            (cmp_enable_o),
        .valid_ireq_o            (valid_ireq_o),
        .ifill_process_started_o (ifill_process_started_o),
        .way_to_replace_o        (way_to_replace_o),
        .flush_en_o              (flush_en_o),
        .flush_idx_o             (flush_idx_o),
        .flush_done_o            (flush_done_o)
    );

    typedef struct {
        bit kill, tv, miss, xcpt, hit, en;
        bit exp_resp, exp_xcpt;
        int nxt; // 0 = back to idle, 1 = waiting on TLB, 2 = issuing fill
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clr();
        ireq_valid_i = 0; ireq_kill_i = 0; flush_i = 0; cache_enable_i = 0;
        tresp_valid_i = 0; tresp_miss_i = 0; tresp_xcpt_i = 0; cmp_hit_i = 0;
        ifill_req_ready_i = 0; ifill_resp_valid_i = 0;
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"}, ireq_ready_o, 1);
        chk({tag, "_fillreq"}, ifill_req_valid_o, 0);
        chk({tag, "_resp"}, resp_valid_o, 0);
        chk({tag, "_xcpt"}, resp_xcpt_o, 0);
        chk({tag, "_cmp"}, cmp_enable_o, 0);
        chk({tag, "_vireq"}, valid_ireq_o, 0);
        chk({tag, "_started"}, ifill_process_started_o, 0);
        chk({tag, "_way"}, way_to_replace_o, 0);
        chk({tag, "_flen"}, flush_en_o, 0);
        chk({tag, "_flidx"}, flush_idx_o, 0);
        chk({tag, "_fldone"}, flush_done_o, 0);
    endtask

    // One request with a cooperative environment. Expected outcome and response cycle
    // come from the protocol rules: k TLB-miss cycles, then compare; a fill adds a
    // request phase of d stalled cycles and r cycles of waiting for data.
    task automatic run_txn(input int k, input int xc, input int hit, input int en,
                           input int d, input int r);
        int  c_cmp, exp_cyc, tmax, resp_cnt, resp_at, resp_x, fills, seen, hs_at;
        bit  hs, fillpath;
        c_cmp    = (k == 0) ? 1 : k + 2;
        fillpath = (xc == 0) && !((hit != 0) && (en != 0));
        exp_cyc  = fillpath ? c_cmp + 2 + d + r : c_cmp;
        tmax     = exp_cyc + 3;
        resp_cnt = 0; resp_at = -1; resp_x = 0; fills = 0; seen = 0; hs_at = 0; hs = 0;
        cyc(); clr(); ireq_valid_i = 1;
        #2 chk("txn_accept_ready", ireq_ready_o, 1);
        for (int t = 1; t <= tmax; t++) begin
            cyc(); clr();
            tresp_valid_i      = 1;
            tresp_miss_i       = (t <= k);
            tresp_xcpt_i       = (xc != 0);
            cmp_hit_i          = (hit != 0);
            cache_enable_i     = (en != 0);
            ifill_req_ready_i  = !hs && (seen >= d);
            ifill_resp_valid_i = hs && (t == hs_at + 1 + r);
            #2;
            if (resp_valid_o) begin
                resp_cnt++; resp_at = t; resp_x = resp_xcpt_o;
            end
            if (ifill_req_valid_o && !hs) begin
                if (ifill_req_ready_i) begin
                    hs = 1; hs_at = t; fills++;
                end else begin
                    seen++;
                end
            end
        end
        if (fillpath && en != 0) way_exp = (way_exp + 1) % 4;
        chk("txn_resp_count", resp_cnt, 1);
        chk("txn_resp_cycle", resp_at, exp_cyc);
        chk("txn_resp_xcpt", resp_x, xc);
        chk("txn_fill_count", fills, fillpath ? 1 : 0);
        chk("txn_way", way_to_replace_o, way_exp);
    endtask

    vec_t vt[8];

    initial begin
        int w, done_cnt, en_cnt;
        vt[0] = '{1, 1, 0, 0, 1, 1, 0, 0, 0};
        vt[1] = '{0, 0, 0, 0, 1, 1, 0, 0, 1};
        vt[2] = '{0, 1, 1, 1, 0, 1, 0, 0, 1};
        vt[3] = '{0, 1, 0, 1, 1, 1, 1, 1, 0};
        vt[4] = '{0, 1, 0, 0, 1, 1, 1, 0, 0};
        vt[5] = '{0, 1, 0, 0, 1, 0, 0, 0, 2};
        vt[6] = '{0, 1, 0, 0, 0, 1, 0, 0, 2};
        vt[7] = '{1, 0, 0, 0, 0, 1, 0, 0, 0};

        clr();
        rstn_i = 0;
        #12 chk_reset_outs("reset");
        @(negedge clk_i);
        rstn_i = 1;

        // Hit with a stray kill in the accept cycle (ignored in IDLE).
        cyc(); clr(); ireq_valid_i = 1; ireq_kill_i = 1; tresp_valid_i = 1; cmp_hit_i = 1; cache_enable_i = 1;
        #2 chk("hit_accept_ready", ireq_ready_o, 1);
        cyc(); clr(); tresp_valid_i = 1; cmp_hit_i = 1; cache_enable_i = 1;
        #2 chk("hit_resp", resp_valid_o, 1);
        chk("hit_xcpt", resp_xcpt_o, 0);
        chk("hit_cmp_en", cmp_enable_o, 1);
        cyc(); clr();
        #2 chk("hit_ready_after", ireq_ready_o, 1);
        chk("hit_single_pulse", resp_valid_o, 0);

        for (int i = 0; i < 8; i++) begin
            cyc(); clr(); ireq_valid_i = 1;
            #2 chk("tbl_accept", ireq_ready_o, 1);
            cyc(); clr();
            ireq_kill_i = vt[i].kill; tresp_valid_i = vt[i].tv; tresp_miss_i = vt[i].miss;
            tresp_xcpt_i = vt[i].xcpt; cmp_hit_i = vt[i].hit; cache_enable_i = vt[i].en;
            #2 chk("tbl_resp", resp_valid_o, vt[i].exp_resp);
            chk("tbl_xcpt", resp_xcpt_o, vt[i].exp_xcpt);
            chk("tbl_cmp_en", cmp_enable_o, 1);
            cyc(); clr();
            #2 chk("tbl_next_live", valid_ireq_o, vt[i].nxt != 0);
            chk("tbl_next_fillreq", ifill_req_valid_o, vt[i].nxt == 2);
            chk("tbl_next_ready", ireq_ready_o, vt[i].nxt == 0);
            if (vt[i].nxt != 0) begin
                cyc(); clr(); ireq_kill_i = 1;
                #2 chk("tbl_kill_no_fillreq", ifill_req_valid_o, 0);
                cyc(); clr();
                #2 chk("tbl_back_idle", ireq_ready_o, 1);
            end
        end

        // Four fills with delayed handshake and data: victim way wraps around.
        for (int i = 0; i < 4; i++) run_txn(0, 0, 0, 1, 3, 5);
        // TLB miss for three cycles then exception: no fill.
        run_txn(3, 1, 0, 1, 0, 0);

        for (int i = 0; i < 30; i++) begin
            run_txn($urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? 1 : 0,
                    $urandom_range(0, 1), ($urandom_range(0, 3) != 0) ? 1 : 0,
                    $urandom_range(0, 3), $urandom_range(0, 5));
        end

        // Kill in FILL_WAIT, data returns four cycles later.
        cyc(); clr(); ireq_valid_i = 1;
        cyc(); clr(); tresp_valid_i = 1; cache_enable_i = 1;
        cyc(); clr(); ifill_req_ready_i = 1; cache_enable_i = 1;
        #2 chk("kill_fillreq_vld", ifill_req_valid_o, 1);
        cyc(); clr(); ireq_kill_i = 1; cache_enable_i = 1;
        #2 chk("kill_started", ifill_process_started_o, 1);
        chk("kill_no_resp", resp_valid_o, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); clr(); cache_enable_i = 1;
            #2 chk("drain_started", ifill_process_started_o, 1);
            chk("drain_not_live", valid_ireq_o, 0);
            chk("drain_no_resp", resp_valid_o, 0);
        end
        cyc(); clr(); cache_enable_i = 1; ifill_resp_valid_i = 1;
        #2 chk("drain_data_no_resp", resp_valid_o, 0);
        cyc(); clr();
        #2 chk("drain_idle_ready", ireq_ready_o, 1);
        chk("drain_idle_started", ifill_process_started_o, 0);
        chk("drain_way", way_to_replace_o, way_exp);

        // Kill and fill data in the same cycle.
        cyc(); clr(); ireq_valid_i = 1;
        cyc(); clr(); tresp_valid_i = 1; cache_enable_i = 1;
        cyc(); clr(); ifill_req_ready_i = 1; cache_enable_i = 1;
        cyc(); clr(); ireq_kill_i = 1; ifill_resp_valid_i = 1; cache_enable_i = 1;
        #2 chk("killresp_no_resp", resp_valid_o, 0);
        cyc(); clr();
        #2 chk("killresp_ready", ireq_ready_o, 1);
        chk("killresp_way", way_to_replace_o, way_exp);

        // Flush requested during FILL_WAIT: fill completes first, then full sweep.
        cyc(); clr(); ireq_valid_i = 1;
        cyc(); clr(); tresp_valid_i = 1; cache_enable_i = 1;
        cyc(); clr(); ifill_req_ready_i = 1; cache_enable_i = 1;
        cyc(); clr(); flush_i = 1; cache_enable_i = 1;
        #2 chk("flfill_no_sweep0", flush_en_o, 0);
        cyc(); clr(); cache_enable_i = 1;
        #2 chk("flfill_no_sweep1", flush_en_o, 0);
        cyc(); clr(); cache_enable_i = 1; ifill_resp_valid_i = 1;
        #2 chk("flfill_resp", resp_valid_o, 1);
        chk("flfill_no_sweep2", flush_en_o, 0);
        way_exp = (way_exp + 1) % 4;
        w = 0;
        do begin
            cyc(); clr();
            #2 w++;
        end while (!flush_en_o && w < 10);
        chk("flush_start", flush_en_o, 1);
        for (int i = 0; i < 64; i++) begin
            if (i > 0) begin
                cyc(); clr(); flush_i = (i == 10);
                #2;
            end
            chk("sweep_en", flush_en_o, 1);
            chk("sweep_idx", flush_idx_o, i);
            chk("sweep_done", flush_done_o, i == 63);
            chk("sweep_ready", ireq_ready_o, 0);
        end
        cyc(); clr();
        #2 chk("sweep_end_en", flush_en_o, 0);
        chk("sweep_end_ready", ireq_ready_o, 1);
        chk("sweep_way", way_to_replace_o, way_exp);

        // Reset in the middle of a sweep.
        run_txn(0, 0, 0, 1, 0, 0);
        if (way_exp == 0) run_txn(0, 0, 0, 1, 0, 0);
        cyc(); clr(); flush_i = 1;
        #2 chk("flush_idle_ready", ireq_ready_o, 0);
        w = 0;
        do begin
            cyc(); clr();
            #2 w++;
        end while (!(flush_en_o && flush_idx_o == 20) && w < 40);
        chk("rst_reach_idx20", flush_idx_o, 20);
        #1 rstn_i = 0;
        #1 chk_reset_outs("rst_mid_sweep");
        way_exp = 0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rstn_i = 1;
        done_cnt = 0; en_cnt = 0;
        for (int i = 0; i < 70; i++) begin
            cyc(); clr();
            #2;
            if (flush_done_o) done_cnt++;
            if (flush_en_o) en_cnt++;
        end
        chk("post_rst_no_done", done_cnt, 0);
        chk("post_rst_no_sweep", en_cnt, 0);
        chk("post_rst_ready", ireq_ready_o, 1);
        chk("post_rst_way", way_to_replace_o, way_exp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
